// File: rtl/freq_bcd_ascii_conv.sv
// Binary-to-BCD converter (sequential double-dabble) with LCD-ready ASCII output.
// Conversions start on a change of data_in and are spaced at least MIN_GAP cycles apart.
module freq_bcd_ascii_conv #(
    parameter int DATA_W  = 22,
    parameter int DIGITS  = 7,
    parameter int MIN_GAP = 1_000_000
) (
    input  logic                  clk_fs,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [8*DIGITS-1:0]   ascii_out,
    output logic                  done,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [8*DIGITS-1:0] ASCII_RST = {{(DIGITS-1){8'h20}}, 8'h30};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]    bcd_sr_q, bcd_sr_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]   last_conv_q, last_conv_d;
    logic [BCD_W-1:0]    bcd_out_q, bcd_out_d;
    logic [8*DIGITS-1:0] ascii_out_q, ascii_out_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [8*DIGITS-1:0] ascii_enc;
    logic                seen_nz;
    logic [3:0]          nib;

    // Add-3 correction for every nibble, and leading-zero-blanked ASCII of the finished result.
    always_comb begin
        bcd_adj   = bcd_sr_q;
        ascii_enc = '0;
        seen_nz   = 1'b0;
        nib       = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_sr_q[4*i +: 4];
            if (nib != 4'h0 || i == 0) begin
                seen_nz = 1'b1;
            end
            ascii_enc[8*i +: 8] = seen_nz ? {4'h3, nib} : 8'h20;
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_sr_d    = bin_sr_q;
        bcd_sr_d    = bcd_sr_q;
        bit_cnt_d   = bit_cnt_q;
        last_conv_d = last_conv_q;
        bcd_out_d   = bcd_out_q;
        ascii_out_d = ascii_out_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        gap_cnt_d   = (gap_cnt_q != '0) ? gap_cnt_q - GAP_W'(1) : gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (data_in != last_conv_q && gap_cnt_q == '0) begin
                    bin_sr_d    = data_in;
                    last_conv_d = data_in;
                    bcd_sr_d    = '0;
                    bit_cnt_d   = '0;
                    gap_cnt_d   = GAP_W'(MIN_GAP - 1);
                    busy_d      = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_out_d   = bcd_sr_q;
                ascii_out_d = ascii_enc;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_fs or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_sr_q    <= '0;
            bcd_sr_q    <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            last_conv_q <= '0;
            bcd_out_q   <= '0;
            ascii_out_q <= ASCII_RST;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            bcd_sr_q    <= bcd_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            last_conv_q <= last_conv_d;
            bcd_out_q   <= bcd_out_d;
            ascii_out_q <= ascii_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bcd_out   = bcd_out_q;
    assign ascii_out = ascii_out_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_freq_bcd_ascii_conv.sv
// Bench for freq_bcd_ascii_conv: two instances (MIN_GAP=1 and MIN_GAP=50) checked by a
// scoreboard fed from a timing/arithmetic reference model.
module tb_freq_bcd_ascii_conv;

    localparam int DATA_W = 22;
    localparam int DIGITS = 7;
    localparam int LAT    = DATA_W + 1;
    localparam logic [55:0] ASCII_RST = 56'h20202020202030;

    typedef struct {
        logic [27:0] bcd;
        logic [55:0] ascii;
        int          doneEdge;
    } exp_t;

    logic        clk;
    logic        rstSig   [2];
    logic [21:0] dataSig  [2];
    logic [27:0] bcdOut   [2];
    logic [55:0] asciiOut [2];
    logic        doneOut  [2];
    logic        busyOut  [2];

    int          minGap   [2];
    exp_t        expQ     [2][$];
    int          cyc;
    int          doneEdge [2];
    int          nextStart[2];
    logic [21:0] lastConv [2];
    logic [27:0] curBcd   [2];
    logic [55:0] curAscii [2];
    int          testsRun;
    int          failCount;

    freq_bcd_ascii_conv #(.DATA_W(DATA_W), .DIGITS(DIGITS), .MIN_GAP(1)) dutFast (
        .clk_fs(clk), .rst(rstSig[0]), .data_in(dataSig[0]),
        .bcd_out(bcdOut[0]), .ascii_out(asciiOut[0]), .done(doneOut[0]), .busy(busyOut[0])
    );

    freq_bcd_ascii_conv #(.DATA_W(DATA_W), .DIGITS(DIGITS), .MIN_GAP(50)) dutGap (
        .clk_fs(clk), .rst(rstSig[1]), .data_in(dataSig[1]),
        .bcd_out(bcdOut[1]), .ascii_out(asciiOut[1]), .done(doneOut[1]), .busy(busyOut[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal digits by repeated division.
    function automatic logic [27:0] refBcd(input int unsigned v);
        logic [27:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // A position is blank once the remaining quotient is zero, except the units place.
    function automatic logic [55:0] refAscii(input int unsigned v);
        logic [55:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[8*i +: 8] = (i == 0 || t != 0) ? 8'(8'h30 + t % 10) : 8'h20;
            t = t / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int d, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d at edge %0d: got %0h, expected %0h",
                     name, d, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [21:0] value, input int cycles);
        dataSig[d] = value;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    // Reference timing model: decides at each edge whether a conversion starts.
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rstSig[d]) begin
                expQ[d].delete();
                lastConv[d]  = '0;
                nextStart[d] = 0;
                doneEdge[d]  = -1;
            end else if (cyc > doneEdge[d] && cyc >= nextStart[d] && dataSig[d] != lastConv[d]) begin
                expQ[d].push_back('{bcd: refBcd(int'(dataSig[d])),
                                    ascii: refAscii(int'(dataSig[d])),
                                    doneEdge: cyc + LAT});
                lastConv[d]  = dataSig[d];
                nextStart[d] = cyc + minGap[d];
                doneEdge[d]  = cyc + LAT;
            end
        end
    end

    // Monitor: pops the scoreboard on done and checks held outputs and busy every cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rstSig[d]) begin
                curBcd[d]   = '0;
                curAscii[d] = ASCII_RST;
            end else if (doneOut[d]) begin
                if (expQ[d].size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpectedDone dut%0d at edge %0d: got done=1, expected done=0",
                             d, cyc);
                end else begin
                    e = expQ[d].pop_front();
                    curBcd[d]   = e.bcd;
                    curAscii[d] = e.ascii;
                    checkOutput("doneEdge", d, 64'(cyc), 64'(e.doneEdge));
                end
            end
            checkOutput("bcd_out", d, 64'(bcdOut[d]), 64'(curBcd[d]));
            checkOutput("ascii_out", d, 64'(asciiOut[d]), 64'(curAscii[d]));
            checkOutput("busy", d, 64'(busyOut[d]),
                        64'(!rstSig[d] && doneEdge[d] >= 0 && cyc < doneEdge[d]));
        end
    end

    initial begin
        logic [21:0] v;
        testsRun  = 0;
        failCount = 0;
        cyc       = 0;
        minGap[0] = 1;
        minGap[1] = 50;
        for (int d = 0; d < 2; d++) begin
            rstSig[d]    = 1'b1;
            dataSig[d]   = '0;
            doneEdge[d]  = -1;
            nextStart[d] = 0;
            lastConv[d]  = '0;
            curBcd[d]    = '0;
            curAscii[d]  = ASCII_RST;
        end
        repeat (3) @(posedge clk);
        #2;
        rstSig[0] = 1'b0;
        rstSig[1] = 1'b0;

        // Idle after reset with zero input: no conversion.
        repeat (100) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            checkOutput("idleBcd", d, 64'(bcdOut[d]), 64'h0);
            checkOutput("idleAscii", d, 64'(asciiOut[d]), 64'(ASCII_RST));
        end

        // Directed values on the back-to-back instance.
        applyStimulus(0, 22'd1234567, 40);
        checkOutput("bcd1234567", 0, 64'(bcdOut[0]), 64'h1234567);
        checkOutput("ascii1234567", 0, 64'(asciiOut[0]), 64'h31323334353637);
        applyStimulus(0, 22'd4194303, 40);
        checkOutput("bcdAllOnes", 0, 64'(bcdOut[0]), 64'h4194303);
        checkOutput("asciiAllOnes", 0, 64'(asciiOut[0]), 64'h34313934333033);
        applyStimulus(0, 22'd100, 40);
        checkOutput("bcd100", 0, 64'(bcdOut[0]), 64'h0000100);
        checkOutput("ascii100", 0, 64'(asciiOut[0]), 64'h20202020313030);

        // Random values, including mid-conversion changes and repeats.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 22'($urandom_range(0, 9));
                1:       v = dataSig[0];
                default: v = 22'($urandom_range(0, 4194303));
            endcase
            applyStimulus(0, v, $urandom_range(1, 40));
        end

        // Rate-limited instance: change during conversion, then hold.
        applyStimulus(1, 22'd5, 5);
        applyStimulus(1, 22'd9, 150);
        checkOutput("gapBcd9", 1, 64'(bcdOut[1]), 64'h9);

        // Reset during SHIFT cycle 10 of a conversion.
        applyStimulus(1, 22'd777, 11);
        rstSig[1] = 1'b1;
        #1;
        checkOutput("rstBcd", 1, 64'(bcdOut[1]), 64'h0);
        checkOutput("rstAscii", 1, 64'(asciiOut[1]), 64'(ASCII_RST));
        checkOutput("rstBusy", 1, 64'(busyOut[1]), 64'h0);
        repeat (3) @(posedge clk);
        #2;
        rstSig[1] = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        checkOutput("bcd777", 1, 64'(bcdOut[1]), 64'h0000777);
        checkOutput("ascii777", 1, 64'(asciiOut[1]), 64'h20202020373737);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 22'($urandom_range(0, 4194303)), $urandom_range(10, 90));
        end

        repeat (200) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            checkOutput("pendingDone", d, 64'(expQ[d].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
